rr_arb_bin: RTL and testbench
=============================

Name: rr_arb_bin

Overview:
- 16-way round-robin arbiter that issues one registered binary grant index (gnt_bin_o) with a valid flag.
- Sits directly upstream of the binary-to-one-hot decoder. gnt_bin_o drives the decoder's bin_i; the decoder's one-hot output becomes the per-requester grant lines.
- The grant is held until the owner signals done, or until a hold-timeout revokes it.

Parameters:
- REQ_W, 16, number of requesters; power of two, 2..16.
- BIN_W, 4, width of the grant index; must equal log2(REQ_W).
- MAX_HOLD, 8, maximum cycles one grant may stay valid before forced revoke; 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  REQ_W  request vector; bit n = requester n wants the resource.
- done_i  input  1  current grant owner releases the resource; sampled only while gnt_valid_o=1.
- gnt_valid_o  output  1  gnt_bin_o holds a live grant.
- gnt_bin_o  output  BIN_W  binary index of the granted requester.
- timeout_o  output  1  one-cycle pulse: the grant was revoked by timeout.

Behaviour:
- Reset (asynchronous assert, sampled release):
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt_valid_o=0, gnt_bin_o=0, timeout_o=0.
  - Reset mid-grant aborts the grant immediately, with no timeout pulse.
- Internal state:
  - ptr (BIN_W): highest-priority index for the next arbitration.
  - hold_cnt (8 bit).
  - 2-state FSM: IDLE, GRANT.
- IDLE:
  - Each edge, search req_i starting at ptr, ascending, wrapping REQ_W-1 -> 0.
  - First set bit n wins: gnt_bin_o<=n, gnt_valid_o<=1, hold_cnt<=1, go GRANT.
  - req_i==0: stay IDLE, outputs unchanged except gnt_valid_o=0.
  - gnt_bin_o keeps its last value while invalid.
- Latency: req_i set before edge k -> gnt_valid_o=1 in the cycle after edge k (1-cycle registered).
- GRANT:
  - gnt_bin_o is stable for the whole grant.
  - req_i is ignored, including a drop of the owner's own request bit. The grant persists until done or timeout.
  - done_i=1 at an edge: gnt_valid_o<=0, ptr<=(gnt_bin_o+1) mod REQ_W, go IDLE.
  - Timeout: done_i=0 and hold_cnt==MAX_HOLD at an edge:
    - gnt_valid_o<=0, timeout_o<=1 for exactly one cycle.
    - ptr<=(gnt_bin_o+1) mod REQ_W, go IDLE.
  - Neither event: hold_cnt<=hold_cnt+1.
  - Simultaneous done_i=1 and hold_cnt==MAX_HOLD: done wins, no timeout pulse.
- Gap between grants: after a release there is always at least one cycle with gnt_valid_o=0 (IDLE arbitration cycle). The maximum grant rate is one grant per 2 cycles when MAX_HOLD=1.
- done_i in IDLE is ignored.
- Wrap: ptr=REQ_W-1 with the owner at REQ_W-1 -> next ptr=0.
- Fairness: with all requests asserted continuously, grants cycle 0,1,2,...,REQ_W-1,0 with no index skipped or repeated.
- timeout_o is 0 in every cycle except the single pulse cycle.

Test Plan:
- Reset values: assert reset mid-cycle with req_i=16'hFFFF -> outputs go 0 immediately (asynchronous). After release, the first grant is gnt_bin_o=0 one cycle after the first edge.
- Rotation: req_i=16'hFFFF held, done_i pulsed every cycle gnt_valid_o=1 -> gnt_bin_o sequence 0,1,...,15,0,1. gnt_valid_o alternates 1/0.
- Wrap search: req_i=16'h0009 (bits 0,3), grant 3 then done -> ptr=4. The next grant is 0 (search wraps past 15).
- Timeout: MAX_HOLD=8, req_i=16'h0020, done_i=0 -> gnt_bin_o=5 valid for exactly 8 cycles. Then timeout_o=1 for one cycle and gnt_valid_o=0. A regrant of 5 follows on the next edge.
- Simultaneous: done_i=1 on the MAX_HOLD-th valid cycle -> release with timeout_o=0.
- Owner drops request: req_i=16'h0004 granted (gnt_bin_o=2), req_i->0 with no done -> gnt_valid_o stays 1 with gnt_bin_o=2 until done or timeout.

Source files
------------

// File: rtl/rr_arb_bin.sv
// rr_arb_bin: round-robin arbiter that issues a registered binary grant index, held until done or a hold-timeout.
module rr_arb_bin #(
    parameter int REQ_W    = 16,
    parameter int BIN_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REQ_W-1:0] req_i,
    input  logic             done_i,
    output logic             gnt_valid_o,
    output logic [BIN_W-1:0] gnt_bin_o,
    output logic             timeout_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           state;
    logic [BIN_W-1:0] ptr;
    logic [7:0]       hold_cnt;
    logic [BIN_W-1:0] win;
    // Descending scan so the last hit is the one closest to ptr; BIN_W-bit adds wrap mod REQ_W.
    always_comb begin
        win = ptr;
        for (int i = REQ_W - 1; i >= 0; i--)
            if (req_i[ptr + BIN_W'(i)]) win = ptr + BIN_W'(i);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            gnt_valid_o <= 1'b0;
            gnt_bin_o   <= '0;
            timeout_o   <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    gnt_valid_o <= |req_i;
                    if (|req_i) begin
                        gnt_bin_o <= win;
                        hold_cnt  <= 8'd1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (done_i || hold_cnt == 8'(MAX_HOLD)) begin
                        gnt_valid_o <= 1'b0;
                        timeout_o   <= !done_i;
                        ptr         <= gnt_bin_o + BIN_W'(1);
                        state       <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arb_bin.sv
// tb_rr_arb_bin: directed stimulus with a cycle-level reference model and hand-computed checkpoints.
module tb_rr_arb_bin;
    localparam int REQ_W = 16, BIN_W = 4, MAX_HOLD = 8;
    logic             clk = 1'b0;
    logic             reset;
    logic [REQ_W-1:0] req;
    logic             done;
    logic             gnt_valid;
    logic [BIN_W-1:0] gnt_bin;
    logic             timeout;
    int vectors = 0, miscompares = 0;
    bit m_busy, m_valid, m_to;
    int m_ptr, m_held, m_bin;

    rr_arb_bin #(.REQ_W(REQ_W), .BIN_W(BIN_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset), .req_i(req), .done_i(done),
        .gnt_valid_o(gnt_valid), .gnt_bin_o(gnt_bin), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [REQ_W-1:0] r, input int p);
        for (int i = 0; i < REQ_W; i++)
            if (r[(p + i) % REQ_W]) return (p + i) % REQ_W;
        return -1;
    endfunction

    // Reference: the first requester at or after ptr wins; a grant lasts until done or MAX_HOLD cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 0; m_valid <= 0; m_to <= 0; m_ptr <= 0; m_held <= 0; m_bin <= 0;
        end else begin
            m_to <= 0;
            if (!m_busy) begin
                m_valid <= pick(req, m_ptr) >= 0;
                if (pick(req, m_ptr) >= 0) begin
                    m_bin <= pick(req, m_ptr); m_busy <= 1; m_held <= 1;
                end
            end else if (done || m_held == MAX_HOLD) begin
                m_busy <= 0; m_valid <= 0; m_to <= !done; m_ptr <= (m_bin + 1) % REQ_W;
            end else begin
                m_held <= m_held + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_valid", int'(gnt_valid), int'(m_valid));
        chk("model_bin", int'(gnt_bin), m_bin);
        chk("model_timeout", int'(timeout), int'(m_to));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input bit v, input int b, input bit t);
        chk({name, "_valid"}, int'(gnt_valid), int'(v));
        chk({name, "_bin"}, int'(gnt_bin), b);
        chk({name, "_timeout"}, int'(timeout), int'(t));
    endtask

    initial begin
        reset = 1; req = '0; done = 0;
        tick(2);
        expect_out("reset", 0, 0, 0);
        reset = 0; req = 16'hFFFF;
        tick(1);
        expect_out("first_grant", 1, 0, 0);
        done = 1;
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            chk("rot_gap_valid", int'(gnt_valid), 0);
            tick(1);
            expect_out("rotation", 1, k % REQ_W, 0);
        end
        req = '0;
        tick(1);
        expect_out("rot_release", 0, 1, 0);
        done = 0; req = 16'h0009;
        tick(1);
        expect_out("wrap_first", 1, 3, 0);
        done = 1;
        tick(1);
        expect_out("wrap_release", 0, 3, 0);
        tick(1);
        expect_out("wrap_search", 1, 0, 0);
        req = '0;
        tick(1);
        done = 0; req = 16'h0020;
        tick(1);
        expect_out("hold_1", 1, 5, 0);
        for (int c = 2; c <= MAX_HOLD; c++) begin
            tick(1);
            expect_out("hold_n", 1, 5, 0);
        end
        tick(1);
        expect_out("timeout_pulse", 0, 5, 1);
        tick(1);
        expect_out("regrant", 1, 5, 0);
        tick(MAX_HOLD - 1);
        expect_out("simul_last", 1, 5, 0);
        done = 1;
        tick(1);
        expect_out("simul_release", 0, 5, 0);
        done = 0; req = '0;
        tick(1);
        req = 16'h0004;
        tick(1);
        expect_out("drop_grant", 1, 2, 0);
        req = '0;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            expect_out("drop_hold", 1, 2, 0);
        end
        #1 reset = 1;
        #1 expect_out("async_reset", 0, 0, 0);
        #3 reset = 0; req = 16'hFFFF;
        tick(1);
        expect_out("post_reset", 1, 0, 0);
        done = 1;
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
